// File: rtl/seq_pattern_tx.sv
// MSB-first serializer with back-to-back word loading and a registered
// reference output for a downstream overlapping 101/110 detector.
module seq_pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             Load_valid,
  output logic             Load_ready,
  output logic             Data_out,
  output logic             Out_valid,
  output logic             Word_done,
  output logic             Match_exp
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [1:0]       hist;
  logic [1:0]       seen;
  logic             last_bit;
  logic             take;
  logic [2:0]       win;

  assign last_bit   = (state == SHIFT) && (cnt == '0);
  assign Out_valid  = (state == SHIFT);
  assign Data_out   = Out_valid & sreg[WIDTH-1];
  assign Word_done  = last_bit;
  assign Load_ready = (state == IDLE) || last_bit;
  assign take       = Load_valid && Load_ready;
  assign win        = {hist, Data_out};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      hist      <= '0;
      seen      <= '0;
      Match_exp <= 1'b0;
    end else begin
      // History spans idle gaps and word boundaries; it is only
      // advanced by bits that actually went out on the line.
      if (Out_valid) begin
        hist      <= {hist[0], Data_out};
        seen      <= (seen == 2'd2) ? seen : seen + 2'd1;
        Match_exp <= (seen == 2'd2) &&
                     ((win == 3'b101) || (win == 3'b110));
      end else begin
        Match_exp <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (take) begin
            sreg  <= Data_in;
            cnt   <= LAST;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (take) begin
            sreg <= Data_in;
            cnt  <= LAST;
          end else if (last_bit) begin
            sreg  <= sreg << 1;
            state <= IDLE;
          end else begin
            sreg <= sreg << 1;
            cnt  <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed and random checks of seq_pattern_tx against a
// queue-based model of the transmitted bit stream.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic [7:0] Data_in;
  logic       Load_valid;
  logic       Load_ready;
  logic       Data_out;
  logic       Out_valid;
  logic       Word_done;
  logic       Match_exp;

  int total = 0;
  int bad   = 0;

  bit   q[$];
  bit   tx[$];
  logic m_match;

  int ov_cnt;
  int m_cnt;
  int wd_cnt;

  seq_pattern_tx #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .Data_in   (Data_in),
    .Load_valid(Load_valid),
    .Load_ready(Load_ready),
    .Data_out  (Data_out),
    .Out_valid (Out_valid),
    .Word_done (Word_done),
    .Match_exp (Match_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    tx.delete();
    m_match = 1'b0;
  endfunction

  function automatic void model_edge(input logic lv, input logic [7:0] d);
    bit acc;
    bit b;
    int n;
    acc = lv && (q.size() <= 1);
    if (q.size() > 0) begin
      b = q.pop_front();
      tx.push_back(b);
      n = tx.size();
      m_match = (n >= 3) &&
        (({tx[n-3], tx[n-2], tx[n-1]} == 3'b101) ||
         ({tx[n-3], tx[n-2], tx[n-1]} == 3'b110));
    end else begin
      m_match = 1'b0;
    end
    if (acc)
      for (int i = 7; i >= 0; i--) q.push_back(d[i]);
  endfunction

  // Called just after a falling edge: check, drive, clock, update model.
  task automatic cyc(input logic lv, input logic [7:0] d);
    logic e_ov;
    e_ov = (q.size() > 0);
    chk("out_valid", Out_valid, e_ov);
    chk("data_out", Data_out, e_ov ? q[0] : 1'b0);
    chk("word_done", Word_done, q.size() == 1);
    chk("load_ready", Load_ready, q.size() <= 1);
    chk("match_exp", Match_exp, m_match);
    if (Out_valid === 1'b1) ov_cnt++;
    if (Match_exp === 1'b1) m_cnt++;
    if (Word_done === 1'b1) wd_cnt++;
    Load_valid = lv;
    Data_in    = d;
    @(posedge clk);
    model_edge(lv, d);
    @(negedge clk);
    Load_valid = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_load_ready", Load_ready, 1'b1);
    chk("rst_out_valid", Out_valid, 1'b0);
    chk("rst_data_out", Data_out, 1'b0);
    chk("rst_word_done", Word_done, 1'b0);
    chk("rst_match_exp", Match_exp, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clr_counts();
    ov_cnt = 0;
    m_cnt  = 0;
    wd_cnt = 0;
  endtask

  initial begin
    rst        = 1'b0;
    Load_valid = 1'b0;
    Data_in    = '0;
    model_reset();
    clr_counts();
    #1;
    chk("por_load_ready", Load_ready, 1'b1);
    chk("por_out_valid", Out_valid, 1'b0);
    chk("por_match_exp", Match_exp, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 8'h00);

    // Single word A0: one 101 match after bit 3.
    clr_counts();
    cyc(1'b1, 8'hA0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00);
    chk("a0_bits", ov_cnt, 8);
    chk("a0_matches", m_cnt, 1);
    chk("a0_word_done", wd_cnt, 1);

    // D8 then 6C back to back with Load_valid held.
    async_reset();
    clr_counts();
    cyc(1'b1, 8'hD8);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h6C);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00);
    chk("d8_6c_bits", ov_cnt, 16);
    chk("d8_6c_matches", m_cnt, 6);
    chk("d8_6c_word_done", wd_cnt, 2);

    // 01, idle gap, 80: 110 spans the gap.
    async_reset();
    clr_counts();
    cyc(1'b1, 8'h01);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h80);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00);
    chk("gap_matches", m_cnt, 1);

    // FF aborted after 3 bits, then 05 with an empty history.
    async_reset();
    clr_counts();
    cyc(1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00);
    async_reset();
    clr_counts();
    cyc(1'b1, 8'h05);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00);
    chk("abort_bits", ov_cnt, 8);
    chk("abort_matches", m_cnt, 1);

    // Load_valid pulses mid-word are ignored.
    clr_counts();
    cyc(1'b1, 8'hC3);
    cyc(1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h33);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00);
    chk("ignore_bits", ov_cnt, 8);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0)
        async_reset();
      else
        cyc($urandom_range(0, 2) == 0, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
